posit_addsub_pipe: RTL and testbench
====================================

Name: posit_addsub_pipe

Overview:
- Parametrised, fully pipelined posit add/subtract unit: successor to the fixed 32-bit/ES=3 adder wrapper.
- Adds generic WIDTH/ES, an add/sub op select, valid/ready streaming with backpressure, a sideband tag, and exception flags.
- Sits between the issue stage and the writeback arbiter of the posit ALU. One operation accepted per cycle when not stalled.

Parameters:
- WIDTH, 32, posit word width in bits (8..64).
- ES, 3, exponent field size in bits (0..4).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state is on the rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- in_valid  in  1  operation present on a, b, sub and in_tag.
- in_ready  out  1  unit can accept an operation this cycle.
- a  in  WIDTH  posit operand A.
- b  in  WIDTH  posit operand B.
- sub  in  1  0 computes a+b; 1 computes a-b.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- q  out  WIDTH  posit result.
- out_tag  out  TAG_W  tag of the result.
- nar  out  1  q is NaR.
- zero  out  1  q is zero.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits clear; out_valid=0; q, out_tag, nar and zero all 0; in_ready=1 on the first cycle after release. Operations in flight during reset are discarded and produce no output.
- Pipeline has 3 registered stages:
  - S1 decode: if sub=1, negate b (two's complement); decode sign, regime k, exponent and fraction with hidden bit; flag zero/NaR.
  - S2 align and add: combined scale = k*2^ES + e; shift the smaller magnitude right, with guard/round/sticky bits; add or subtract magnitudes by sign.
  - S3 normalise, round, encode: leading-zero normalise; round to nearest, ties to even, on the encoded bit pattern; encode the result.
- Latency: exactly 3 cycles from an accepted input to out_valid, when there is no stall. Throughput is 1 per cycle.
- Handshake:
  - An input is accepted on a cycle where in_valid and in_ready are both 1.
  - The output is consumed on a cycle where out_valid and out_ready are both 1.
  - Global stall: in_ready = !out_valid | out_ready. When stalled, every stage holds its contents.
  - q, out_tag, nar and zero are held stable while out_valid=1 and out_ready=0.
  - Bubbles propagate. in_ready does not depend combinationally on in_valid.
- Special cases:
  - Either operand NaR (sign bit only) gives NaR: q = 1 followed by WIDTH-1 zeros, nar=1.
  - 0 ± x gives ±x exactly. x - x gives 0 with zero=1. There is no negative zero.
  - Results beyond maxpos saturate to ±maxpos; results below minpos in magnitude round to ±minpos. An exact-zero sum is the only way to produce 0. Saturation never produces NaR.
  - sub=1 with b=NaR gives NaR.
- Internal widths:
  - Aligned adder width = WIDTH + 3 (guard, round, sticky) + 1 (carry).
  - The shift amount saturates at the adder width; bits shifted out beyond it fold into sticky.
- out_tag is the in_tag of the same operation. Ordering is strictly FIFO.

Test Plan (WIDTH=32, ES=3):
- Reset then stimulus:
  - Hold rst=0 with in_valid=1 → out_valid=0, in_ready=1 after release.
  - Assert rst mid-stream with 2 operations in flight → neither operation ever appears at the output.
- Basic add: a=0x40000000 (1.0), b=0x40000000, sub=0, tag=5 → 3 cycles later q=0x44000000 (2.0), out_tag=5, zero=0, nar=0.
- Mixed scale and subtract:
  - a=0x40000000, b=0x3C000000 (0.5), sub=0 → q=0x42000000 (1.5).
  - a=0x40000000, b=0x40000000, sub=1 → q=0x00000000, zero=1.
  - a=0x40000000, b=0xC0000000 (-1.0), sub=1 → q=0x44000000.
- Exceptions:
  - a=0x80000000, b=0x40000000 → q=0x80000000, nar=1.
  - a=0x7FFFFFFF, b=0x7FFFFFFF → q=0x7FFFFFFF (saturate), nar=0.
  - a=0x00000001, b=0x00000001 → q=0x00000001 (round to minpos).
- Backpressure: stream 8 operations (tags 0..7) with in_valid=1 and out_ready toggling on a 1-on/2-off pattern → all 8 results emerge in tag order with none lost or duplicated; q stays stable while stalled; in_ready=0 exactly on stalled cycles.
- Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 → out_valid pattern 1,0,1,0 starting at cycle 3; throughput 1 per cycle with in_valid held at 1.

Source files
------------

// File: rtl/posit_addsub_pipe.sv
// posit_addsub_pipe: 3-stage pipelined posit add/subtract with valid/ready backpressure,
// a sideband tag and NaR/zero flags.
module posit_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int ES    = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [TAG_W-1:0] out_tag,
    output logic             nar,
    output logic             zero
);
    localparam int AW  = WIDTH + 4;
    localparam int LW  = $clog2(AW + 1);
    localparam int SW  = $clog2(WIDTH) + ES + 3;
    localparam int FW  = AW - 1;
    localparam int EFW = ES + FW;
    localparam int PAD = WIDTH - 3;
    localparam int PW  = 2 + EFW + PAD;
    localparam logic signed [SW-1:0] KMAX = SW'(WIDTH - 2);
    localparam logic signed [SW-1:0] KMIN = SW'(1 - WIDTH);
    localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

    // m is 1.fraction with the hidden bit at the top; m == 0 marks a zero operand
    typedef struct packed {
        logic             s;
        logic [SW-1:0]    sc;
        logic [WIDTH-1:0] m;
    } op_t;

    function automatic logic [LW-1:0] clz(input logic [AW-1:0] v);
        logic [LW-1:0] n;
        n = LW'(AW);
        for (int i = 0; i < AW; i++)
            if (v[i]) n = LW'(AW - 1 - i);
        return n;
    endfunction

    function automatic op_t decode(input logic [WIDTH-1:0] x);
        op_t              r;
        logic [WIDTH-2:0] body;
        logic [WIDTH-2:0] rem;
        logic [LW-1:0]    run;
        logic [SW-1:0]    k;
        body = (WIDTH-1)'(x[WIDTH-1] ? -x : x);
        run  = clz({body[WIDTH-2] ? ~body : body, 5'b11111});
        rem  = (body << run) << 1;
        k    = body[WIDTH-2] ? SW'(run) - SW'(1) : -SW'(run);
        r.s  = x[WIDTH-1];
        r.sc = (k << ES) + SW'(rem >> (WIDTH - 1 - ES));
        r.m  = ~|x ? '0 : {1'b1, rem << ES};
        return r;
    endfunction

    logic                 en;
    logic                 v1, v2, n1, n2, s2;
    op_t                  a1, b1;
    logic [TAG_W-1:0]     t1, t2;
    logic [SW-1:0]        sc2;
    logic [AW-1:0]        sum2;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    logic                 a_big;
    op_t                  lg, sm;
    logic signed [SW-1:0] diff;
    logic [LW-1:0]        sh;
    logic [2*AW-1:0]      wide;
    logic [AW-1:0]        lg_al, sm_al;

    always_comb begin
        a_big = ~|b1.m || (|a1.m && ($signed(a1.sc) > $signed(b1.sc) || (a1.sc == b1.sc && a1.m >= b1.m)));
        lg    = a_big ? a1 : b1;
        sm    = a_big ? b1 : a1;
        diff  = $signed(lg.sc) - $signed(sm.sc);
        sh    = diff >= SW'(AW) ? LW'(AW) : LW'(diff);
        wide  = {1'b0, sm.m, 3'b000, {AW{1'b0}}} >> sh;
        lg_al = {1'b0, lg.m, 3'b000};
        sm_al = wide[2*AW-1:AW] | AW'(|wide[AW-1:0]);
    end

    logic [LW-1:0]        lz;
    logic [FW-1:0]        frac;
    logic signed [SW-1:0] sc3, k3;
    logic [PW-1:0]        x3;
    logic signed [PW-1:0] sx;
    logic [WIDTH-2:0]     body3, rb;
    logic                 up;
    logic [WIDTH-1:0]     mag, q_n;

    // Regime is built by arithmetic-shifting a 2-bit seed (10 or 01) so the run length follows k
    always_comb begin
        lz    = clz(sum2);
        frac  = FW'(sum2 << lz);
        sc3   = $signed(sc2) + SW'(1) - SW'(lz);
        k3    = sc3 >>> ES;
        x3    = {k3[SW-1] ? 2'b01 : 2'b10, (EFW'(sc3) << FW) | EFW'(frac), {PAD{1'b0}}};
        sx    = $signed(x3) >>> (k3[SW-1] ? ~k3 : k3);
        body3 = sx[PW-1 -: WIDTH-1];
        up    = sx[PW-WIDTH] & (|sx[PW-WIDTH-1:0] | body3[0]);
        rb    = k3 >= KMAX ? '1 : k3 <= KMIN ? (WIDTH-1)'(1) : body3 + (WIDTH-1)'(up);
        mag   = {1'b0, rb};
        q_n   = n2 ? NAR : ~|sum2 ? '0 : s2 ? -mag : mag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            n1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            t1        <= '0;
            v2        <= 1'b0;
            n2        <= 1'b0;
            s2        <= 1'b0;
            sc2       <= '0;
            sum2      <= '0;
            t2        <= '0;
            out_valid <= 1'b0;
            q         <= '0;
            out_tag   <= '0;
            nar       <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            n1        <= a == NAR || b == NAR;
            a1        <= decode(a);
            b1        <= decode(sub ? -b : b);
            t1        <= in_tag;
            v2        <= v1;
            n2        <= n1;
            s2        <= lg.s;
            sc2       <= lg.sc;
            sum2      <= lg.s == sm.s ? lg_al + sm_al : lg_al - sm_al;
            t2        <= t1;
            out_valid <= v2;
            q         <= q_n;
            out_tag   <= t2;
            nar       <= n2;
            zero      <= !n2 && ~|sum2;
        end
    end
endmodule

// File: tb/tb_posit_addsub_pipe.sv
// tb_posit_addsub_pipe: directed vectors with hand-computed posit results (WIDTH=32, ES=3).
module tb_posit_addsub_pipe;
    logic        clk = 0, rst = 0, in_valid = 0, sub = 0, out_ready = 1;
    logic        in_ready, out_valid, nar, zero;
    logic [31:0] a = 0, b = 0, q;
    logic [3:0]  in_tag = 0, out_tag;
    int          errors = 0, checks = 0;

    posit_addsub_pipe #(.WIDTH(32), .ES(3), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .q(q),
        .out_tag(out_tag), .nar(nar), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic op(input string name, input logic [31:0] ta, input logic [31:0] tb2,
                      input logic ts, input logic [3:0] tt, input logic [31:0] eq,
                      input logic en, input logic ez);
        int n;
        @(negedge clk);
        a = ta; b = tb2; sub = ts; in_tag = tt; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, ".lat"}, n, 3);
        check({name, ".q"}, q, eq);
        check({name, ".tag"}, out_tag, tt);
        check({name, ".nar"}, nar, en);
        check({name, ".zero"}, zero, ez);
    endtask

    task automatic pattern(input string name, input logic [3:0] pv);
        a = 32'h40000000; b = 32'h40000000; sub = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                check($sformatf("%s.v%0d", name, i - 3), out_valid, pv[i-3]);
                if (pv[i-3]) begin
                    check($sformatf("%s.q%0d", name, i - 3), q, 32'h44000000);
                    check($sformatf("%s.t%0d", name, i - 3), out_tag, 4'(i - 3));
                end
            end
            in_tag   = 4'(i);
            in_valid = (i < 4) && pv[i%4];
        end
        in_valid = 0;
    endtask

    initial begin : main
        int          sent, rcv, cyc, seen;
        logic        hold_v;
        logic [31:0] hold_q;
        in_valid = 1; a = 32'h40000000; b = 32'h40000000;
        repeat (3) @(negedge clk);
        check("rst.out_valid", out_valid, 0);
        check("rst.q", q, 0);
        check("rst.flags", {nar, zero, out_tag}, 0);
        rst = 1; in_valid = 0;
        @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid_after", out_valid, 0);

        op("add",      32'h40000000, 32'h40000000, 0, 4'd5,  32'h44000000, 0, 0);
        op("half",     32'h40000000, 32'h3C000000, 0, 4'd1,  32'h42000000, 0, 0);
        op("self_sub", 32'h40000000, 32'h40000000, 1, 4'd2,  32'h00000000, 0, 1);
        op("sub_neg",  32'h40000000, 32'hC0000000, 1, 4'd3,  32'h44000000, 0, 0);
        op("nar_a",    32'h80000000, 32'h40000000, 0, 4'd4,  32'h80000000, 1, 0);
        op("nar_b",    32'h40000000, 32'h80000000, 1, 4'd6,  32'h80000000, 1, 0);
        op("sat",      32'h7FFFFFFF, 32'h7FFFFFFF, 0, 4'd7,  32'h7FFFFFFF, 0, 0);
        op("sat_neg",  32'h80000001, 32'h7FFFFFFF, 1, 4'd14, 32'h80000001, 0, 0);
        op("minpos",   32'h00000001, 32'h00000001, 0, 4'd8,  32'h00000001, 0, 0);
        op("zero_add", 32'h00000000, 32'h3C000000, 0, 4'd9,  32'h3C000000, 0, 0);
        op("zero_sub", 32'h00000000, 32'h42000000, 1, 4'd10, 32'hBE000000, 0, 0);
        op("neg_sum",  32'hC0000000, 32'h3C000000, 0, 4'd11, 32'hC4000000, 0, 0);
        op("tie_even", 32'h40000000, 32'h06800000, 0, 4'd12, 32'h40000000, 0, 0);
        op("tie_up",   32'h40000001, 32'h06800000, 0, 4'd13, 32'h40000002, 0, 0);

        @(negedge clk);
        a = 32'h40000000; b = 32'h40000000; sub = 0; in_tag = 1; in_valid = 1;
        @(negedge clk);
        in_tag = 2;
        @(negedge clk);
        in_valid = 0; rst = 0;
        #1 check("mid.out_valid_in_rst", out_valid, 0);
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid.no_output", seen, 0);

        pattern("bubble", 4'b0101);
        pattern("stream", 4'b1111);

        sent = 0; rcv = 0; cyc = 0; hold_v = 0; hold_q = 0;
        while (rcv < 8 && cyc < 200) begin
            @(negedge clk);
            if (hold_v) begin
                check("bp.hold_v", out_valid, 1);
                check("bp.hold_q", q, hold_q);
            end
            out_ready = (cyc % 3 == 0);
            in_valid  = sent < 8;
            a = 32'h40000000 + 32'(sent); b = a; sub = 0; in_tag = 4'(sent);
            #1;
            check("bp.in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                check("bp.q", q, 32'h44000000 + 32'(rcv));
                check("bp.tag", out_tag, 4'(rcv));
                rcv++;
            end
            hold_v = out_valid && !out_ready;
            hold_q = q;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check("bp.count", rcv, 8);
        @(negedge clk);
        out_ready = 1; in_valid = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp.no_extra", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
